// File: rtl/vga_pixel_queue.sv
// Elastic pixel-write queue between the game-flow mux and the VGA adapter.
// Optional macro VGA_PIXEL_QUEUE_TRANSPARENT_DROP_EN discards writes whose colour is 9'h1FF.
module vga_pixel_queue #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [8:0]       in_colour,
  input  logic [14:0]      in_coord,
  input  logic             in_we,
  input  logic             out_ready,
  input  logic             clear_stats,
  output logic [7:0]       out_x,
  output logic [6:0]       out_y,
  output logic [8:0]       out_colour,
  output logic             out_plot,
  output logic             full,
  output logic             empty,
  output logic             overflow,
  output logic [CNT_W-1:0] drop_count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] OCC_FULL = (AW+1)'(DEPTH);

  localparam logic [0:0] StEmpty = 1'b0;
  localparam logic [0:0] StShow  = 1'b1;

  logic [7:0]       in_x;
  logic [6:0]       in_y;
  logic [23:0]      in_word;
  logic             on_screen;
  logic             wr_valid;

  logic [23:0]      mem [DEPTH];
  logic [0:0]       state_q, state_d;
  logic [AW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [AW:0]      occ_q, occ_d, fifo_cnt;
  logic [23:0]      out_data_q, out_data_d;
  logic             full_q, empty_q, overflow_q;
  logic [CNT_W-1:0] drop_count_q;

  logic pop, push, drop, load, fifo_has, bypass, mem_wr, mem_rd;

  assign in_x      = in_coord[14:7];
  assign in_y      = in_coord[6:0];
  assign in_word   = {in_x, in_y, in_colour};
  assign on_screen = (in_x < 8'd160) && (in_y < 7'd120);

`ifdef VGA_PIXEL_QUEUE_TRANSPARENT_DROP_EN
  assign wr_valid = in_we && on_screen && (in_colour != 9'h1FF);
`else
  assign wr_valid = in_we && on_screen;
`endif

  // Occupancy includes the presented pixel, so the stored entries exclude it.
  assign fifo_cnt = occ_q - {{AW{1'b0}}, state_q};
  assign fifo_has = (fifo_cnt != '0);
  assign pop      = (state_q == StShow) && out_ready;
  assign push     = wr_valid && ((occ_q != OCC_FULL) || pop);
  assign drop     = wr_valid && !push;
  assign load     = (state_q == StEmpty) || pop;
  assign bypass   = load && !fifo_has && push;
  assign mem_wr   = push && !bypass;
  assign mem_rd   = load && fifo_has;

  always_comb begin
    state_d    = state_q;
    out_data_d = out_data_q;
    if (load) begin
      if (fifo_has) begin
        state_d    = StShow;
        out_data_d = mem[rd_ptr_q];
      end else if (push) begin
        state_d    = StShow;
        out_data_d = in_word;
      end else begin
        state_d    = StEmpty;
      end
    end
  end

  always_comb begin
    occ_d = occ_q;
    case ({push, pop})
      2'b10:   occ_d = occ_q + (AW+1)'(1);
      2'b01:   occ_d = occ_q - (AW+1)'(1);
      default: occ_d = occ_q;
    endcase
  end

  // Storage is left unreset; only pointers and occupancy define its contents.
  always_ff @(posedge clk) begin
    if (mem_wr) mem[wr_ptr_q] <= in_word;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StEmpty;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      occ_q      <= '0;
      out_data_q <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      out_data_q <= out_data_d;
      occ_q      <= occ_d;
      full_q     <= (occ_d == OCC_FULL);
      empty_q    <= (occ_d == '0);
      if (mem_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (mem_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  // Clear takes priority over a drop in the same cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else if (clear_stats) begin
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else if (drop) begin
      overflow_q <= 1'b1;
      if (drop_count_q != '1) drop_count_q <= drop_count_q + CNT_W'(1);
    end
  end

  assign out_x      = out_data_q[23:16];
  assign out_y      = out_data_q[15:9];
  assign out_colour = out_data_q[8:0];
  assign out_plot   = (state_q == StShow);
  assign full       = full_q;
  assign empty      = empty_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_vga_pixel_queue.sv
// Scoreboard bench for vga_pixel_queue: stimulus pushes expected pixels,
// a negedge monitor pops and compares on every handshake.
module tb_vga_pixel_queue;

  logic        clk = 1'b0;
  logic        resetn;
  logic [8:0]  in_colour;
  logic [14:0] in_coord;
  logic        in_we;
  logic        out_ready;
  logic        clear_stats;
  logic [7:0]  out_x;
  logic [6:0]  out_y;
  logic [8:0]  out_colour;
  logic        out_plot;
  logic        full;
  logic        empty;
  logic        overflow;
  logic [15:0] drop_count;

  int total = 0;
  int bad   = 0;
  logic [23:0] sb[$];

  vga_pixel_queue #(.DEPTH(16), .CNT_W(16)) dut (
    .clk(clk), .resetn(resetn), .in_colour(in_colour), .in_coord(in_coord),
    .in_we(in_we), .out_ready(out_ready), .clear_stats(clear_stats),
    .out_x(out_x), .out_y(out_y), .out_colour(out_colour), .out_plot(out_plot),
    .full(full), .empty(empty), .overflow(overflow), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] x, input logic [6:0] y, input logic [8:0] c,
                    input bit accept);
    in_we     = 1'b1;
    in_coord  = {x, y};
    in_colour = c;
    if (accept) sb.push_back({x, y, c});
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_x"}, out_x, 0);
    check({tag, "_y"}, out_y, 0);
    check({tag, "_colour"}, out_colour, 0);
    check({tag, "_plot"}, out_plot, 0);
    check({tag, "_full"}, full, 0);
    check({tag, "_empty"}, empty, 1);
    check({tag, "_overflow"}, overflow, 0);
    check({tag, "_drops"}, drop_count, 0);
  endtask

  // Monitor: ordering against the scoreboard and stability under backpressure.
  logic [23:0] held;
  bit          hold = 0;
  always @(negedge clk) begin
    if (!resetn) begin
      hold = 0;
    end else begin
      if (hold) check("hold_stable", {out_x, out_y, out_colour}, held);
      if (out_plot && out_ready) begin
        if (sb.size() == 0) check("sb_underflow", out_plot, 0);
        else check("pixel", {out_x, out_y, out_colour}, sb.pop_front());
      end
      hold = out_plot && !out_ready;
      held = {out_x, out_y, out_colour};
    end
  end

  initial begin
    int n;
    resetn = 1'b0; in_colour = '0; in_coord = '0; in_we = 1'b0;
    out_ready = 1'b0; clear_stats = 1'b0;
    #12;
    check_reset("rst");
    resetn = 1'b1;

    // Single write with latency of one edge
    tick();
    out_ready = 1'b1;
    wr(8'd10, 7'd20, 9'h1C0, 1);
    tick();
    in_we = 1'b0;
    check("single_plot", out_plot, 1);
    check("single_x", out_x, 10);
    check("single_y", out_y, 20);
    check("single_colour", out_colour, 9'h1C0);
    tick();
    check("single_gone", out_plot, 0);
    check("single_empty", empty, 1);

    // Off-screen writes vanish without being counted
    wr(8'd160, 7'd5, 9'h0F0, 0);
    tick();
    wr(8'd3, 7'd120, 9'h00F, 0);
    tick();
    in_we = 1'b0;
    tick();
    check("offscr_plot", out_plot, 0);
    check("offscr_empty", empty, 1);
    check("offscr_overflow", overflow, 0);
    check("offscr_drops", drop_count, 0);

    // Fill with backpressure: 16 accepted, 4 lost
    out_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      wr(8'(i * 7), 7'(i + 3), 9'(i * 19 + 1), i < 16);
      tick();
      if (i == 14) check("fill_not_full", full, 0);
      if (i == 15) check("fill_full", full, 1);
    end
    check("fill_drops", drop_count, 4);
    check("fill_overflow", overflow, 1);

    // Drop and clear in the same cycle: clear wins
    wr(8'd1, 7'd1, 9'h001, 0);
    clear_stats = 1'b1;
    tick();
    clear_stats = 1'b0;
    in_we = 1'b0;
    check("clr_drops", drop_count, 0);
    check("clr_overflow", overflow, 0);
    check("clr_full", full, 1);

    // Full queue with simultaneous push and pop
    out_ready = 1'b1;
    wr(8'd50, 7'd60, 9'h0AA, 1);
    tick();
    in_we = 1'b0;
    check("pp_full", full, 1);
    check("pp_drops", drop_count, 0);
    n = 0;
    while (!empty && n < 40) begin
      tick();
      n++;
    end
    check("drain_cycles", n, 16);
    check("drain_empty", empty, 1);
    check("drain_sb", sb.size(), 0);

    // Stream with out_ready toggling every cycle
    for (int i = 0; i < 12; i++) begin
      out_ready = i[0];
      wr(8'(100 + i), 7'(2 * i + 1), 9'(9'h100 + i * 5), 1);
      tick();
    end
    in_we = 1'b0;
    n = 0;
    while (!empty && n < 100) begin
      out_ready = ~out_ready;
      tick();
      n++;
    end
    check("bp_empty", empty, 1);
    check("bp_drops", drop_count, 0);
    check("bp_sb", sb.size(), 0);

    // Transparency key colour
    out_ready = 1'b1;
`ifdef VGA_PIXEL_QUEUE_TRANSPARENT_DROP_EN
    wr(8'd5, 7'd5, 9'h1FF, 0);
    tick();
    in_we = 1'b0;
    check("key_plot", out_plot, 0);
`else
    wr(8'd5, 7'd5, 9'h1FF, 1);
    tick();
    in_we = 1'b0;
    check("key_plot", out_plot, 1);
`endif
    tick();
    tick();
    check("key_drops", drop_count, 0);

    // Asynchronous reset mid-stream
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wr(8'(20 + i), 7'(30 + i), 9'(9'h055 + i), 1);
      tick();
    end
    in_we = 1'b0;
    check("pre_rst_plot", out_plot, 1);
    #2 resetn = 1'b0;
    #1;
    check_reset("async_rst");
    sb.delete();
    #3 resetn = 1'b1;
    tick();
    check("post_rst_empty", empty, 1);
    check("final_sb", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_pixel_queue.md
# vga_pixel_queue

Elastic write buffer between the game-flow pixel mux and the VGA adapter. It accepts one pixel write per cycle (colour + packed coordinate + write-enable) and splits the coordinate into x/y. Off-screen writes are discarded; accepted writes are queued in a FIFO and drained to the adapter under a ready handshake. Drawing engines never stall, and lost writes are counted.

## Interface
Parameters:
- DEPTH, 16 — FIFO entries; power of two, 2..256.
- CNT_W, 16 — width of drop counter.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous, active-low reset.
- in_colour  in  9  pixel colour {R3,G3,B3}.
- in_coord  in  15  packed coordinate {x[7:0], y[6:0]}.
- in_we  in  1  write strobe; one pixel per cycle while high.
- out_ready  in  1  adapter can accept a pixel this cycle.
- clear_stats  in  1  synchronous clear of drop_count and overflow.
- out_x  out  8  pixel x, 0..159.
- out_y  out  7  pixel y, 0..119.
- out_colour  out  9  pixel colour.
- out_plot  out  1  out_* hold a valid pixel.
- full  out  1  occupancy == DEPTH.
- empty  out  1  occupancy == 0 and no pixel presented.
- overflow  out  1  sticky: a valid write was lost because the queue was full.
- drop_count  out  CNT_W  writes lost to overflow, saturating.

## Operation
- Input filter, evaluated in the same cycle as in_we: x = in_coord[14:7], y = in_coord[6:0]. The write is valid iff x < 160 and y < 120. Invalid writes are silently discarded; they are not counted and do not set overflow.
- Push: a valid write is stored when occupancy < DEPTH, or when occupancy == DEPTH and a pop happens in the same cycle.
  - Otherwise the write is lost: overflow <= 1 and drop_count increments, saturating at all-ones.
- Output stage is one register, modelled as a two-state FSM:
  - EMPTY → SHOW when the FIFO is non-empty, or a push arrives while the FIFO is empty (bypass).
  - SHOW → SHOW on out_ready while further data is available; SHOW → EMPTY on out_ready with nothing left.
  - SHOW with out_ready low: out_* are held stable.
- Pop = out_plot && out_ready. The next entry loads on that same edge.
- Occupancy counts FIFO entries plus the presented pixel. Pointers wrap modulo DEPTH. Counter width is clog2(DEPTH)+1.
- Order is strictly preserved.
- clear_stats zeroes drop_count and overflow. If a drop occurs in the same cycle, clear wins.
- Reset value of every output: out_x = 0, out_y = 0, out_colour = 0, out_plot = 0, full = 0, empty = 1, overflow = 0, drop_count = 0. Pointers and occupancy are also cleared.
- Reset mid-operation discards all queued pixels immediately.

## Timing
- Latency: valid write sampled at edge k into an empty queue → out_plot = 1 and out_* valid after edge k (visible in cycle k+1).
- Throughput: one pixel per cycle in and out. With out_ready held high, a continuous stream never fills the queue.
- full, empty and overflow are registered and update on the same edge as the occupancy change.
- Handshake: out_* must not change while out_plot = 1 and out_ready = 0.
- out_ready is ignored while out_plot = 0.

## Configuration
- VGA_PIXEL_QUEUE_TRANSPARENT_DROP_EN: when defined, a write with in_colour == 9'h1FF (transparency key) is treated as invalid and discarded like an off-screen write.
- When undefined, 9'h1FF is queued and output as an ordinary colour.

## Test plan
- Single write, in_coord = {8'd10, 7'd20}, in_colour = 9'h1C0, out_ready = 1 → next cycle out_plot = 1, out_x = 10, out_y = 20, out_colour = 9'h1C0; one cycle later out_plot = 0 and empty = 1.
- Off-screen writes: x = 160, y = 5 and x = 3, y = 120 → never appear on the output; overflow = 0, drop_count = 0.
- out_ready = 0, 20 consecutive valid writes with DEPTH = 16 → full = 1 after 16; drop_count = 4, overflow = 1. Raise out_ready → 16 pixels emerge in order, one per cycle, then empty = 1.
- Full queue, simultaneous push and pop → push accepted, occupancy stays 16, drop_count unchanged.
- Backpressure: toggle out_ready every cycle during a stream → out_* stable whenever out_ready = 0; no loss or duplication. Scoreboard matches the input order.
- Colour 9'h1FF at a valid coordinate → discarded with VGA_PIXEL_QUEUE_TRANSPARENT_DROP_EN defined, output without it. Asserting resetn = 0 mid-stream → every output returns to its reset value asynchronously.
